// File: rtl/throw_trajectory.sv
// Projectile flight for the throw UI: detects the power-bar release, latches the force and
// integrates a ballistic path on a fixed step tick until it hits, lands or leaves the screen.
module throw_trajectory #(
    parameter int STEP_INTERVAL = 1_083_333,
    parameter int X_LAUNCH      = 100,
    parameter int Y_LAUNCH      = 500,
    parameter int GROUND_Y      = 700,
    parameter int SCREEN_W      = 1024,
    parameter int TARGET_X_MIN  = 800,
    parameter int TARGET_X_MAX  = 900,
    parameter int TARGET_Y_MIN  = 560,
    parameter int TARGET_Y_MAX  = 700
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               space,
    input  logic [9:0]         throw_force,
    output logic               in_flight,
    output logic [11:0]        proj_x,
    output logic signed [11:0] proj_y,
    output logic               done,
    output logic [1:0]         result
);

    localparam int CNT_W = (STEP_INTERVAL > 1) ? $clog2(STEP_INTERVAL) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(STEP_INTERVAL - 1);
    localparam logic [11:0]        X_LAUNCH_V = 12'(X_LAUNCH);
    localparam logic signed [11:0] Y_LAUNCH_S = 12'(Y_LAUNCH);
    localparam logic signed [11:0] GROUND_S   = 12'(GROUND_Y);
    localparam logic [11:0]        SCREEN_V   = 12'(SCREEN_W);
    localparam logic [11:0]        TX_MIN_V   = 12'(TARGET_X_MIN);
    localparam logic [11:0]        TX_MAX_V   = 12'(TARGET_X_MAX);
    localparam logic signed [11:0] TY_MIN_S   = 12'(TARGET_Y_MIN);
    localparam logic signed [11:0] TY_MAX_S   = 12'(TARGET_Y_MAX);

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_FLIGHT, S_DONE} state_t;

    state_t             state, state_next;
    logic               space_d;
    logic [CNT_W-1:0]   step_cnt, step_cnt_next;
    logic [7:0]         vx, vx_next;
    logic signed [11:0] vy, vy_next;
    logic [11:0]        proj_x_next;
    logic signed [11:0] proj_y_next;
    logic               in_flight_next, done_next;
    logic [1:0]         result_next;

    logic               release_evt, force_ok, step_tick;
    logic [11:0]        nx;
    logic signed [11:0] ny;
    logic               hit, ground, off_screen, terminate;

    // Candidate position for the next step; termination is judged on it, not the current one.
    always_comb begin
        release_evt = space_d & ~space;
        force_ok    = (throw_force[9:2] != 8'd0);
        step_tick   = (state == S_FLIGHT) && (step_cnt == CNT_LAST);
        nx          = proj_x + {4'b0000, vx};
        ny          = proj_y + vy;
        hit         = (nx >= TX_MIN_V) && (nx <= TX_MAX_V) && (ny >= TY_MIN_S) && (ny <= TY_MAX_S);
        ground      = (ny >= GROUND_S);
        off_screen  = (nx >= SCREEN_V);
        terminate   = hit | ground | off_screen;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            space_d <= 1'b0;
        end else begin
            state   <= state_next;
            space_d <= space;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (release_evt) state_next = S_ARM;
            S_ARM:    state_next = force_ok ? S_FLIGHT : S_IDLE;
            S_FLIGHT: if (step_tick && terminate) state_next = S_DONE;
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_comb begin
        step_cnt_next  = step_cnt;
        vx_next        = vx;
        vy_next        = vy;
        proj_x_next    = proj_x;
        proj_y_next    = proj_y;
        in_flight_next = in_flight;
        done_next      = 1'b0;
        result_next    = result;
        case (state)
            S_ARM: begin
                if (force_ok) begin
                    vx_next        = throw_force[9:2];
                    vy_next        = -$signed({4'b0000, throw_force[9:2]});
                    proj_x_next    = X_LAUNCH_V;
                    proj_y_next    = Y_LAUNCH_S;
                    step_cnt_next  = '0;
                    result_next    = 2'd0;
                    in_flight_next = 1'b1;
                end
            end
            S_FLIGHT: begin
                if (step_tick) begin
                    step_cnt_next = '0;
                    vy_next       = vy + 12'sd1;
                    proj_x_next   = nx;
                    proj_y_next   = ny;
                    if (hit) begin
                        result_next = 2'd1;
                    end else if (ground) begin
                        result_next = 2'd2;
                        proj_y_next = GROUND_S;
                    end else if (off_screen) begin
                        result_next = 2'd3;
                    end
                    if (terminate) begin
                        in_flight_next = 1'b0;
                        done_next      = 1'b1;
                    end
                end else begin
                    step_cnt_next = step_cnt + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_cnt  <= '0;
            vx        <= 8'd0;
            vy        <= 12'sd0;
            proj_x    <= X_LAUNCH_V;
            proj_y    <= Y_LAUNCH_S;
            in_flight <= 1'b0;
            done      <= 1'b0;
            result    <= 2'd0;
        end else begin
            step_cnt  <= step_cnt_next;
            vx        <= vx_next;
            vy        <= vy_next;
            proj_x    <= proj_x_next;
            proj_y    <= proj_y_next;
            in_flight <= in_flight_next;
            done      <= done_next;
            result    <= result_next;
        end
    end

endmodule

// File: tb/tb_throw_trajectory.sv
// Bench for throw_trajectory: directed throws plus random forces, compared step by step
// against an integer trajectory model.
module tb_throw_trajectory;

    localparam int N = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               space;
    logic [9:0]         throw_force;
    logic               in_flight;
    logic [11:0]        proj_x;
    logic signed [11:0] proj_y;
    logic               done;
    logic [1:0]         result;

    int errors = 0;
    int checks = 0;
    int exp_x[$];
    int exp_y[$];
    int exp_res;
    int last_x, last_y, last_res;

    throw_trajectory #(.STEP_INTERVAL(N)) dut (
        .clk(clk), .rst(rst), .space(space), .throw_force(throw_force),
        .in_flight(in_flight), .proj_x(proj_x), .proj_y(proj_y),
        .done(done), .result(result)
    );

    always #5 clk = ~clk;

    initial begin
        #500_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Plain ballistic integration with the hit / ground / out rules in priority order.
    task automatic modelFlight(input int f);
        int x, y, vx, vy, nx, ny, steps;
        exp_x.delete();
        exp_y.delete();
        exp_res = 0;
        vx = f / 4;
        vy = -(f / 4);
        x = 100;
        y = 500;
        steps = 0;
        while (exp_res == 0 && steps < 1000) begin
            nx = x + vx;
            ny = y + vy;
            vy = vy + 1;
            if (nx >= 800 && nx <= 900 && ny >= 560 && ny <= 700) exp_res = 1;
            else if (ny >= 700) begin
                exp_res = 2;
                ny = 700;
            end else if (nx >= 1024) exp_res = 3;
            x = nx;
            y = ny;
            exp_x.push_back(x);
            exp_y.push_back(y);
            steps++;
        end
    endtask

    task automatic applyStimulus(input int f, input int hold);
        space = 1'b1;
        repeat (hold) tick();
        space = 1'b0;
        throw_force = 10'(f);
        tick();
        tick();
    endtask

    task automatic flyAndCheck(input int f, input bit meddle, input int reset_step);
        bit seen_done;
        int last;
        if (f < 4) begin
            checkOutput("discard in_flight", int'(in_flight), 0);
            checkOutput("discard proj_x", int'(proj_x), last_x);
            checkOutput("discard proj_y", int'(proj_y), last_y);
            checkOutput("discard result", int'(result), last_res);
            seen_done = done;
            repeat (2 * N) begin
                tick();
                seen_done = seen_done | done | in_flight;
            end
            checkOutput("discard no done/flight", int'(seen_done), 0);
            return;
        end
        modelFlight(f);
        if (exp_res == 0) checkOutput("model terminates", 0, 1);
        checkOutput("launch in_flight", int'(in_flight), 1);
        checkOutput("launch proj_x", int'(proj_x), 100);
        checkOutput("launch proj_y", int'(proj_y), 500);
        checkOutput("launch result", int'(result), 0);
        last = exp_x.size() - 1;
        for (int k = 0; k <= last; k++) begin
            for (int c = 0; c < N; c++) begin
                space = (meddle && k < last) ? 1'($urandom_range(0, 1)) : 1'b0;
                tick();
            end
            checkOutput($sformatf("x step %0d", k + 1), int'(proj_x), exp_x[k]);
            checkOutput($sformatf("y step %0d", k + 1), int'(proj_y), exp_y[k]);
            checkOutput($sformatf("in_flight step %0d", k + 1), int'(in_flight), (k == last) ? 0 : 1);
            checkOutput($sformatf("done step %0d", k + 1), int'(done), (k == last) ? 1 : 0);
            if (reset_step == k + 1 && k < last) begin
                rst = 1'b1;
                tick();
                checkOutput("reset in_flight", int'(in_flight), 0);
                checkOutput("reset done", int'(done), 0);
                checkOutput("reset proj_x", int'(proj_x), 100);
                checkOutput("reset proj_y", int'(proj_y), 500);
                checkOutput("reset result", int'(result), 0);
                rst = 1'b0;
                space = 1'b0;
                tick();
                last_x = 100;
                last_y = 500;
                last_res = 0;
                return;
            end
        end
        checkOutput("final result", int'(result), exp_res);
        tick();
        checkOutput("after done pulse", int'(done), 0);
        checkOutput("after in_flight", int'(in_flight), 0);
        checkOutput("result held", int'(result), exp_res);
        last_x = exp_x[last];
        last_y = exp_y[last];
        last_res = exp_res;
    endtask

    initial begin
        int f, hold;
        rst = 1'b1;
        space = 1'b0;
        throw_force = 10'd0;
        tick();
        tick();
        checkOutput("reset in_flight", int'(in_flight), 0);
        checkOutput("reset done", int'(done), 0);
        checkOutput("reset result", int'(result), 0);
        checkOutput("reset proj_x", int'(proj_x), 100);
        checkOutput("reset proj_y", int'(proj_y), 500);
        rst = 1'b0;
        tick();
        last_x = 100;
        last_y = 500;
        last_res = 0;

        applyStimulus(68, 10);  flyAndCheck(68, 1'b0, 0);
        applyStimulus(64, 3);   flyAndCheck(64, 1'b0, 0);
        applyStimulus(128, 2);  flyAndCheck(128, 1'b0, 0);
        applyStimulus(3, 4);    flyAndCheck(3, 1'b0, 0);
        applyStimulus(64, 2);   flyAndCheck(64, 1'b0, 0);
        applyStimulus(64, 2);   flyAndCheck(64, 1'b1, 0);
        applyStimulus(68, 5);   flyAndCheck(68, 1'b0, 20);
        applyStimulus(68, 3);   flyAndCheck(68, 1'b0, 0);

        for (int i = 0; i < 12; i++) begin
            f = (i % 3 == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 1023));
            hold = int'($urandom_range(1, 6));
            applyStimulus(f, hold);
            flyAndCheck(f, 1'($urandom_range(0, 1)), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
